// File: rtl/axi_dbg_bridge.sv
// rtl/axi_dbg_bridge.sv - host byte-stream to single-beat 32-bit AXI4 master bridge
// Optional inter-byte timeout in GET_ADDR/GET_DATA when DBG_BRIDGE_TIMEOUT_EN is defined.
package utils_pkg;
    typedef struct packed {
        logic [7:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [7:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [7:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [7:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;
endpackage

module axi_dbg_bridge
    import utils_pkg::*;
#(
    parameter logic [7:0] AXI_ID         = 8'd0,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output s_axi_mosi_t axi_mosi_o,
    input  s_axi_miso_t axi_miso_i,
    output logic        busy_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_AXI_AW_W, S_AXI_B,
        S_AXI_AR, S_AXI_R, S_TX_STATUS, S_TX_DATA
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_cnt;
    logic        r_is_read, r_aw_done, r_w_done;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  r_status;
    logic        w_rx_hs, w_tx_hs, w_timeout, w_cmd_ok;
    logic        w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic        w_unused;

    assign w_rx_hs  = rx_valid_i & rx_ready_o;
    assign w_tx_hs  = tx_valid_o & tx_ready_i;
    assign w_cmd_ok = (rx_data_i == 8'h57) || (rx_data_i == 8'h52);
    assign busy_o   = (r_state != S_IDLE);
    assign w_unused = ^{axi_miso_i.bid, axi_miso_i.rid, axi_miso_i.rlast, (TIMEOUT_CYCLES > 0)};

`ifdef DBG_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          w_in_get;

    assign w_in_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_timeout = w_in_get && !w_rx_hs && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)
            r_tmo_cnt <= '0;
        else if (!w_in_get || w_rx_hs)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        rx_ready_o  = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i)
                    w_state_nxt = w_cmd_ok ? S_GET_ADDR : S_TX_STATUS;
            end
            S_GET_ADDR: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && r_cnt == 2'd3)
                    w_state_nxt = r_is_read ? S_AXI_AR : S_GET_DATA;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_GET_DATA: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && r_cnt == 2'd3)
                    w_state_nxt = S_AXI_AW_W;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_AXI_AW_W: begin
                // Each channel retires on its own handshake; leave once both have.
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || axi_miso_i.awready) && (r_w_done || axi_miso_i.wready))
                    w_state_nxt = S_AXI_B;
            end
            S_AXI_B: begin
                w_bready = 1'b1;
                if (axi_miso_i.bvalid)
                    w_state_nxt = S_TX_STATUS;
            end
            S_AXI_AR: begin
                w_arvalid = 1'b1;
                if (axi_miso_i.arready)
                    w_state_nxt = S_AXI_R;
            end
            S_AXI_R: begin
                w_rready = 1'b1;
                if (axi_miso_i.rvalid)
                    w_state_nxt = S_TX_STATUS;
            end
            S_TX_STATUS: begin
                tx_valid_o = 1'b1;
                tx_data_o  = r_status;
                if (tx_ready_i)
                    w_state_nxt = (r_is_read && r_status == 8'h00) ? S_TX_DATA : S_IDLE;
            end
            S_TX_DATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = r_rdata[7:0];
                if (tx_ready_i && r_cnt == 2'd3)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_is_read <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_status  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (w_rx_hs) begin
                    r_is_read <= (rx_data_i == 8'h52);
                    r_cnt     <= 2'd0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (!w_cmd_ok)
                        r_status <= 8'hEE;
                end
                S_GET_ADDR: if (w_rx_hs) begin
                    r_addr <= {rx_data_i, r_addr[31:8]};
                    r_cnt  <= r_cnt + 2'd1;
                end
                S_GET_DATA: if (w_rx_hs) begin
                    r_wdata <= {rx_data_i, r_wdata[31:8]};
                    r_cnt   <= r_cnt + 2'd1;
                end
                S_AXI_AW_W: begin
                    if (axi_miso_i.awready) r_aw_done <= 1'b1;
                    if (axi_miso_i.wready)  r_w_done  <= 1'b1;
                end
                S_AXI_B: if (axi_miso_i.bvalid)
                    r_status <= {6'b0, axi_miso_i.bresp};
                S_AXI_R: if (axi_miso_i.rvalid) begin
                    r_status <= {6'b0, axi_miso_i.rresp};
                    r_rdata  <= axi_miso_i.rdata;
                end
                S_TX_DATA: if (w_tx_hs) begin
                    r_rdata <= {8'h00, r_rdata[31:8]};
                    r_cnt   <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        axi_mosi_o         = '0;
        axi_mosi_o.awid    = AXI_ID;
        axi_mosi_o.awaddr  = {r_addr[31:2], 2'b00};
        axi_mosi_o.awsize  = 3'b010;
        axi_mosi_o.awburst = 2'b01;
        axi_mosi_o.awvalid = w_awvalid;
        axi_mosi_o.wdata   = r_wdata;
        axi_mosi_o.wstrb   = 4'hF;
        axi_mosi_o.wlast   = 1'b1;
        axi_mosi_o.wvalid  = w_wvalid;
        axi_mosi_o.bready  = w_bready;
        axi_mosi_o.arid    = AXI_ID;
        axi_mosi_o.araddr  = {r_addr[31:2], 2'b00};
        axi_mosi_o.arsize  = 3'b010;
        axi_mosi_o.arburst = 2'b01;
        axi_mosi_o.arvalid = w_arvalid;
        axi_mosi_o.rready  = w_rready;
    end
endmodule

// File: tb/tb_axi_dbg_bridge.sv
// tb/tb_axi_dbg_bridge.sv - self-checking bench for axi_dbg_bridge
module tb_axi_dbg_bridge;
    import utils_pkg::*;

    logic        clk      = 1'b0;
    logic        arst     = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          cfg_aw_dly = 0, cfg_w_dly = 0;
    logic [1:0]  cfg_resp   = 2'b00;
    logic [31:0] cfg_rdata  = 32'h0;
    int          aw_wait = 0, w_wait = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, aw_stall = 0, w_stall = 0;
    logic [31:0] aw_prev = 32'h0, w_prev = 32'h0;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_unstable = 0, n_fixed_bad = 0;
    logic [31:0] seen_awaddr = 32'h0, seen_wdata = 32'h0, seen_araddr = 32'h0;
    int          b_aw, b_w, b_ar, b_b, b_r;

    bit          tx_hold = 0, rand_tx = 0, tx_stall = 0;
    logic [7:0]  tx_prev = 8'h00;
    logic [7:0]  tx_q[$];
    int          n_tx_unstable = 0, n_rx_in_tx = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          awd;
        int          wd;
        logic [31:0] exp_addr;
        logic [7:0]  exp_status;
        int          exp_ntx;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    axi_dbg_bridge #(.AXI_ID(8'h03), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .arst(arst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .axi_mosi_o(mosi), .axi_miso_i(miso), .busy_o(busy)
    );

    always @(negedge clk)
        tx_ready = tx_hold ? 1'b0 : (rand_tx ? 1'($urandom_range(0, 1)) : 1'b1);

    // AXI slave: drives at the falling edge, so any handshake it grants lands on the next rising edge
    always @(negedge clk) begin
        if (!arst) begin
            miso = '0;
            aw_wait = 0; w_wait = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_stall = 0; w_stall = 0;
        end else begin
            if (b_pend && mosi.bready) begin
                miso.bvalid = 1'b1; miso.bresp = cfg_resp; b_pend = 0; n_b++;
            end else miso.bvalid = 1'b0;
            if (r_pend && mosi.rready) begin
                miso.rvalid = 1'b1; miso.rdata = cfg_rdata; miso.rresp = cfg_resp; miso.rlast = 1'b1;
                r_pend = 0; n_r++;
            end else begin
                miso.rvalid = 1'b0; miso.rdata = $urandom;
            end
            if (mosi.awvalid) begin
                if (aw_stall && mosi.awaddr !== aw_prev) n_unstable++;
                if (aw_wait >= cfg_aw_dly) begin
                    miso.awready = 1'b1; n_aw++; seen_awaddr = mosi.awaddr; aw_got = 1; aw_wait = 0;
                    if (mosi.awid !== 8'h03 || mosi.awlen !== 8'h0 || mosi.awsize !== 3'b010 ||
                        mosi.awburst !== 2'b01 || mosi.awlock !== 1'b0 || mosi.awcache !== 4'h0 ||
                        mosi.awprot !== 3'h0) n_fixed_bad++;
                end else begin
                    miso.awready = 1'b0; aw_wait++;
                end
            end else begin
                miso.awready = 1'b0; aw_wait = 0;
            end
            aw_stall = mosi.awvalid && !miso.awready;
            aw_prev  = mosi.awaddr;
            if (mosi.wvalid) begin
                if (w_stall && mosi.wdata !== w_prev) n_unstable++;
                if (w_wait >= cfg_w_dly) begin
                    miso.wready = 1'b1; n_w++; seen_wdata = mosi.wdata; w_got = 1; w_wait = 0;
                    if (mosi.wstrb !== 4'hF || mosi.wlast !== 1'b1) n_fixed_bad++;
                end else begin
                    miso.wready = 1'b0; w_wait++;
                end
            end else begin
                miso.wready = 1'b0; w_wait = 0;
            end
            w_stall = mosi.wvalid && !miso.wready;
            w_prev  = mosi.wdata;
            if (aw_got && w_got) begin
                b_pend = 1; aw_got = 0; w_got = 0;
            end
            miso.arready = mosi.arvalid;
            if (mosi.arvalid) begin
                n_ar++; seen_araddr = mosi.araddr; r_pend = 1;
                if (mosi.arid !== 8'h03 || mosi.arlen !== 8'h0 || mosi.arsize !== 3'b010 ||
                    mosi.arburst !== 2'b01) n_fixed_bad++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (tx_stall && tx_valid && tx_data !== tx_prev) n_tx_unstable++;
            if (tx_valid && rx_ready) n_rx_in_tx++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            tx_stall = tx_valid && !tx_ready;
            tx_prev  = tx_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (rx_ready) break;
            @(negedge clk);
        end
        check("rx_accept", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data, input int gap);
        send_byte(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 0; i < 4; i++) begin
                repeat (gap) @(negedge clk);
                send_byte(addr[8*i +: 8]);
            end
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) begin
                repeat (gap) @(negedge clk);
                send_byte(data[8*i +: 8]);
            end
    endtask

    task automatic prep(input logic [1:0] resp, input int awd, input int wd, input logic [31:0] data);
        cfg_resp = resp; cfg_aw_dly = awd; cfg_w_dly = wd; cfg_rdata = data;
        b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_b = n_b; b_r = n_r;
        tx_q.delete();
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    // Reference: what the host should see and which AXI beats should appear for one command
    task automatic check_model(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        logic [7:0] exp_q[$];
        int exp_wr, exp_rd;
        exp_q = {};
        exp_wr = (cmd == 8'h57) ? 1 : 0;
        exp_rd = (cmd == 8'h52) ? 1 : 0;
        if (exp_wr + exp_rd == 0) exp_q.push_back(8'hEE);
        else exp_q.push_back({6'd0, resp});
        if (exp_rd == 1 && resp == 2'b00)
            for (int i = 0; i < 4; i++) exp_q.push_back(8'((data >> (8 * i)) & 32'hFF));
        check("tx_count", 64'(tx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check("tx_byte", 64'(tx_q[i]), 64'(exp_q[i]));
        check("aw_count", 64'(n_aw - b_aw), 64'(exp_wr));
        check("w_count", 64'(n_w - b_w), 64'(exp_wr));
        check("b_count", 64'(n_b - b_b), 64'(exp_wr));
        check("ar_count", 64'(n_ar - b_ar), 64'(exp_rd));
        check("r_count", 64'(n_r - b_r), 64'(exp_rd));
        if (exp_wr == 1) begin
            check("awaddr", 64'(seen_awaddr), 64'(addr - (addr % 4)));
            check("wdata", 64'(seen_wdata), 64'(data));
        end
        if (exp_rd == 1)
            check("araddr", 64'(seen_araddr), 64'(addr - (addr % 4)));
    endtask

    initial begin
        logic [7:0]  r_cmd;
        logic [31:0] r_addr, r_data;
        logic [1:0]  r_resp;
        int          k;

        vecs[0] = '{8'h57, 32'h1000_0000, 32'hDEAD_BEEF, 2'b00, 0, 0, 32'h1000_0000, 8'h00, 1};
        vecs[1] = '{8'h52, 32'h1000_0004, 32'hCAFE_F00D, 2'b00, 0, 0, 32'h1000_0004, 8'h00, 5};
        vecs[2] = '{8'h52, 32'h5000_0003, 32'h1234_5678, 2'b10, 0, 0, 32'h5000_0000, 8'h02, 1};
        vecs[3] = '{8'h57, 32'h2000_0008, 32'h1234_5678, 2'b00, 5, 0, 32'h2000_0008, 8'h00, 1};
        vecs[4] = '{8'h57, 32'h2000_000E, 32'hA5A5_5A5A, 2'b00, 0, 5, 32'h2000_000C, 8'h00, 1};
        vecs[5] = '{8'h41, 32'h0,         32'h0,         2'b00, 0, 0, 32'h0,         8'hEE, 1};
        vecs[6] = '{8'h57, 32'h3000_0001, 32'h0BAD_F00D, 2'b10, 3, 3, 32'h3000_0000, 8'h02, 1};
        vecs[7] = '{8'h52, 32'h0000_0002, 32'h8765_4321, 2'b00, 0, 0, 32'h0000_0000, 8'h00, 5};

        repeat (2) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_axi_valids", 64'({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready}), 64'd0);
        arst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            prep(vecs[i].resp, vecs[i].awd, vecs[i].wd, vecs[i].data);
            send_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].data, 0);
            wait_idle();
            check_model(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].resp);
            check("vec_ntx", 64'(tx_q.size()), 64'(vecs[i].exp_ntx));
            if (tx_q.size() > 0) check("vec_status", 64'(tx_q[0]), 64'(vecs[i].exp_status));
            if (vecs[i].cmd == 8'h57) check("vec_awaddr", 64'(seen_awaddr), 64'(vecs[i].exp_addr));
            if (vecs[i].cmd == 8'h52) check("vec_araddr", 64'(seen_araddr), 64'(vecs[i].exp_addr));
        end

        // Host stalls the response for ten cycles
        tx_hold = 1'b1;
        prep(2'b00, 0, 0, 32'h0102_0304);
        send_cmd(8'h52, 32'h4000_0010, 32'h0, 0);
        for (k = 0; k < 100; k++) begin
            if (tx_valid) break;
            @(negedge clk);
        end
        check("bp_tx_valid", 64'(tx_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_data", 64'(tx_data), 64'h00);
            check("bp_rx_ready", 64'(rx_ready), 64'd0);
        end
        tx_hold = 1'b0;
        wait_idle();
        check_model(8'h52, 32'h4000_0010, 32'h0102_0304, 2'b00);

        // Partial command followed by a long gap
        prep(2'b00, 0, 0, 32'h0);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (20) @(negedge clk);
`ifdef DBG_BRIDGE_TIMEOUT_EN
        check("tmo_idle", 64'(busy), 64'd0);
        check("tmo_rx_ready", 64'(rx_ready), 64'd1);
        check("tmo_no_aw", 64'(n_aw - b_aw), 64'd0);
        check("tmo_no_tx", 64'(tx_q.size()), 64'd0);
        prep(2'b00, 0, 0, 32'h55AA_33CC);
        send_cmd(8'h52, 32'h0, 32'h0, 0);
        wait_idle();
        check_model(8'h52, 32'h0, 32'h55AA_33CC, 2'b00);
`else
        check("partial_busy", 64'(busy), 64'd1);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_idle();
        check_model(8'h57, 32'h1000_0000, 32'h4433_2211, 2'b00);
`endif

        // Reset while both write channels are still waiting
        prep(2'b00, 50, 50, 32'h0);
        send_cmd(8'h57, 32'h6000_0000, 32'h0000_0001, 0);
        @(negedge clk);
        check("mr_awvalid_before", 64'(mosi.awvalid), 64'd1);
        #2 arst = 1'b0;
        #1;
        check("mr_awvalid", 64'(mosi.awvalid), 64'd0);
        check("mr_wvalid", 64'(mosi.wvalid), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_rx_ready", 64'(rx_ready), 64'd1);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        check("mr_no_aw", 64'(n_aw - b_aw), 64'd0);

        rand_tx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) r_cmd = 8'h57;
            else if (k < 8) r_cmd = 8'h52;
            else begin
                r_cmd = 8'($urandom_range(0, 255));
                if (r_cmd == 8'h57 || r_cmd == 8'h52) r_cmd = 8'h00;
            end
            r_addr = $urandom;
            r_data = $urandom;
            r_resp = 2'($urandom_range(0, 3));
            prep(r_resp, $urandom_range(0, 4), $urandom_range(0, 4), r_data);
            send_cmd(r_cmd, r_addr, r_data, $urandom_range(0, 2));
            wait_idle();
            check_model(r_cmd, r_addr, r_data, r_resp);
        end
        rand_tx = 1'b0;

        check("aw_w_stable", 64'(n_unstable), 64'd0);
        check("fixed_fields", 64'(n_fixed_bad), 64'd0);
        check("tx_stable", 64'(n_tx_unstable), 64'd0);
        check("rx_ready_in_tx", 64'(n_rx_in_tx), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
